// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared widths, park constant and word types for the PWM duty scheduler
package pwm_pkg;

    localparam int PWM_WIDTH    = 17;
    localparam int PWM_HRBITS   = 3;
    localparam int PWM_DITHBITS = 4;

    function automatic int coarse_width(input int width, input int hrbits);
        return width - hrbits;
    endfunction

    localparam int PWM_CW = coarse_width(PWM_WIDTH, PWM_HRBITS);

    // Coarse field all ones can never match tb, so the output never toggles.
    localparam logic [PWM_WIDTH-1:0] PARK = {{PWM_CW{1'b1}}, {PWM_HRBITS{1'b0}}};

    typedef struct packed {
        logic [PWM_WIDTH+PWM_DITHBITS-1:0] duty;
        logic [PWM_WIDTH-1:0]              phase;
    } pwm_upd_t;

    typedef struct packed {
        logic [PWM_WIDTH-1:0] cmp_h;
        logic [PWM_WIDTH-1:0] cmp_l;
    } pwm_cmp_t;

endpackage

// File: rtl/pwm_dither.sv
// rtl/pwm_dither.sv - first-order sigma-delta accumulator for sub-LSB duty
module pwm_dither #(
    parameter int DITHBITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                step,
    input  logic [DITHBITS-1:0] frac,
    output logic                carry
);

    logic [DITHBITS-1:0] acc;
    logic [DITHBITS:0]   sum;

    // Carry is combinational so the caller can use it on the stepping edge.
    assign sum   = {1'b0, acc} + {1'b0, frac};
    assign carry = sum[DITHBITS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (step) begin
            acc <= sum[DITHBITS-1:0];
        end
    end

endmodule

// File: rtl/pwm_duty_sched.sv
// rtl/pwm_duty_sched.sv - timebase, shadowed duty/phase update and compare build for one PWM channel
module pwm_duty_sched
    import pwm_pkg::*;
#(
    parameter int WIDTH    = PWM_WIDTH,
    parameter int HRBITS   = PWM_HRBITS,
    parameter int DITHBITS = PWM_DITHBITS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [WIDTH-HRBITS-1:0]   period,
    input  logic                      upd_valid,
    output logic                      upd_ready,
    input  logic [WIDTH+DITHBITS-1:0] upd_duty,
    input  logic [WIDTH-1:0]          upd_phase,
    output logic [WIDTH-HRBITS-1:0]   tb,
    output logic [WIDTH-1:0]          cmpH,
    output logic [WIDTH-1:0]          cmpL,
    output logic                      wrap
);

    localparam int CW = WIDTH - HRBITS;

    logic [CW-1:0]    per_q, per_in, per_cur;
    logic             loaded_q;
    logic             shadow_full;
    pwm_upd_t         shadow_q, active_q, next_act;
    logic             apply_now, carry;
    logic [WIDTH-1:0] p_fine, ph;
    logic [WIDTH:0]   d_eff, s;
    pwm_cmp_t         cmp_next;

    assign per_in    = (period < CW'(2)) ? CW'(2) : period;
    // Until the first latch after reset the live input stands in for per_q.
    assign per_cur   = loaded_q ? per_q : per_in;
    assign upd_ready = !shadow_full;
    assign apply_now = en && wrap;
    assign next_act  = shadow_full ? shadow_q : active_q;

    pwm_dither #(.DITHBITS(DITHBITS)) u_dither (
        .clk   (clk),
        .rst   (rst),
        .clear (!en),
        .step  (apply_now),
        .frac  (next_act.duty[DITHBITS-1:0]),
        .carry (carry)
    );

    always_comb begin
        p_fine         = {per_q, {HRBITS{1'b0}}};
        ph             = (next_act.phase >= p_fine) ? next_act.phase - p_fine : next_act.phase;
        d_eff          = {1'b0, next_act.duty[WIDTH+DITHBITS-1:DITHBITS]} + {{WIDTH{1'b0}}, carry};
        s              = {1'b0, ph} + d_eff;
        cmp_next.cmp_h = PARK;
        cmp_next.cmp_l = PARK;
        if (d_eff == '0) begin
            cmp_next.cmp_h = PARK;
        end else if (d_eff >= {1'b0, p_fine}) begin
            cmp_next.cmp_h = ph;
        end else begin
            cmp_next.cmp_h = ph;
            cmp_next.cmp_l = WIDTH'((s >= {1'b0, p_fine}) ? s - {1'b0, p_fine} : s);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tb          <= '0;
            wrap        <= 1'b0;
            per_q       <= '0;
            loaded_q    <= 1'b0;
            shadow_q    <= '0;
            shadow_full <= 1'b0;
            active_q    <= '0;
            cmpH        <= PARK;
            cmpL        <= PARK;
        end else begin
            if (!en) begin
                tb       <= '0;
                wrap     <= 1'b0;
                per_q    <= per_in;
                loaded_q <= 1'b1;
            end else if (tb == per_cur - 1'b1) begin
                tb       <= '0;
                wrap     <= 1'b1;
                per_q    <= per_in;
                loaded_q <= 1'b1;
            end else begin
                tb       <= tb + 1'b1;
                wrap     <= 1'b0;
                per_q    <= per_cur;
                loaded_q <= 1'b1;
            end

            // A full shadow blocks acceptance, so load and apply never collide.
            if (upd_valid && !shadow_full) begin
                shadow_q    <= {upd_duty, upd_phase};
                shadow_full <= 1'b1;
            end else if (apply_now && shadow_full) begin
                shadow_full <= 1'b0;
            end

            if (apply_now) begin
                active_q <= next_act;
                cmpH     <= cmp_next.cmp_h;
                cmpL     <= cmp_next.cmp_l;
            end else if (!en) begin
                cmpH <= PARK;
                cmpL <= PARK;
            end
        end
    end

endmodule

// File: tb/tb_pwm_duty_sched.sv
// tb/tb_pwm_duty_sched.sv - scoreboard bench for pwm_duty_sched against a behavioural period model
module tb_pwm_duty_sched;
    import pwm_pkg::*;

    localparam int W  = PWM_WIDTH;
    localparam int HR = PWM_HRBITS;
    localparam int DB = PWM_DITHBITS;
    localparam int CW = PWM_CW;

    logic          clk = 1'b0;
    logic          rst, en, upd_valid, upd_ready, wrap;
    logic [CW-1:0] period, tb;
    logic [W+DB-1:0] upd_duty;
    logic [W-1:0]  upd_phase, cmpH, cmpL;

    int passed = 0;
    int total  = 0;
    bit model_on = 1'b0;

    int m_tb, m_wrap, m_per, m_acc, m_duty, m_phase;
    pwm_upd_t pend[$];
    pwm_cmp_t expq[$];

    pwm_duty_sched dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .period    (period),
        .upd_valid (upd_valid),
        .upd_ready (upd_ready),
        .upd_duty  (upd_duty),
        .upd_phase (upd_phase),
        .tb        (tb),
        .cmpH      (cmpH),
        .cmpL      (cmpL),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act == expv) passed++;
        else $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
    endtask

    task automatic timeout(input string name);
        total++;
        $display("FAIL %s actual=timeout expected=event at %0t", name, $time);
    endtask

    function automatic int clamp_per(input int p);
        return (p < 2) ? 2 : p;
    endfunction

    // Compare pair from the arithmetic rules: period in fine LSBs, phase folded once.
    function automatic pwm_cmp_t ref_cmp(input int d, input int phase, input int per);
        pwm_cmp_t r;
        int pf, ph, s;
        pf = per * (1 << HR);
        ph = (phase >= pf) ? phase - pf : phase;
        s  = ph + d;
        r.cmp_h = PARK;
        r.cmp_l = PARK;
        if (d != 0) begin
            r.cmp_h = W'(ph);
            if (d < pf) r.cmp_l = W'((s >= pf) ? s - pf : s);
        end
        return r;
    endfunction

    always @(negedge clk) begin : model
        pwm_upd_t w;
        int       acc_sum, d;
        bit       rdy;
        if (model_on) begin
            chk("tb", int'(tb), m_tb);
            chk("wrap", int'(wrap), m_wrap);
            rdy = (pend.size() == 0);
            chk("upd_ready", int'(upd_ready), int'(rdy));
            if (m_wrap != 0) begin
                if (pend.size() != 0) begin
                    w = pend.pop_front();
                    m_duty  = int'(w.duty);
                    m_phase = int'(w.phase);
                end
                acc_sum = m_acc + (m_duty % (1 << DB));
                m_acc   = acc_sum % (1 << DB);
                d       = (m_duty >> DB) + ((acc_sum >= (1 << DB)) ? 1 : 0);
                expq.push_back(ref_cmp(d, m_phase, m_per));
            end
            if (upd_valid && rdy) begin
                w.duty  = upd_duty;
                w.phase = upd_phase;
                pend.push_back(w);
            end
            if (m_tb == m_per - 1) begin
                m_tb   = 0;
                m_wrap = 1;
                m_per  = clamp_per(int'(period));
            end else begin
                m_tb++;
                m_wrap = 0;
            end
        end
    end

    initial begin : monitor
        pwm_cmp_t e;
        bit prev = 1'b0;
        forever begin
            @(negedge clk);
            if (model_on && prev) begin
                if (expq.size() == 0) begin
                    timeout("sb_expected_entry");
                end else begin
                    e = expq.pop_front();
                    chk("cmpH", int'(cmpH), int'(e.cmp_h));
                    chk("cmpL", int'(cmpL), int'(e.cmp_l));
                end
            end
            prev = wrap;
        end
    end

    task automatic send(input int duty, input int phase);
        int n = 0;
        upd_duty  = (W+DB)'(duty);
        upd_phase = W'(phase);
        upd_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!upd_ready && n < 3000);
        if (!upd_ready) timeout("send_handshake");
        @(posedge clk);
        #1 upd_valid = 1'b0;
    endtask

    task automatic wait_wraps(input int n);
        int seen = 0;
        int cyc  = 0;
        while (seen < n && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (wrap) seen++;
        end
        if (seen < n) timeout("wait_wrap");
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        int cnt11, gap, cyc, d;
        rst = 1'b1; en = 1'b0; period = CW'(100);
        upd_valid = 1'b0; upd_duty = '0; upd_phase = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tb", int'(tb), 0);
        chk("rst_wrap", int'(wrap), 0);
        chk("rst_cmpH", int'(cmpH), int'(PARK));
        chk("rst_cmpL", int'(cmpL), int'(PARK));
        chk("rst_ready", int'(upd_ready), 1);
        en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_tb = 0; m_wrap = 0; m_per = 100; m_acc = 0; m_duty = 0; m_phase = 0;
        model_on = 1'b1;

        repeat (250) @(posedge clk);
        #1;

        send(400 << DB, 0);
        wait_wraps(1);
        chk("duty400_cmpH", int'(cmpH), 0);
        chk("duty400_cmpL", int'(cmpL), 400);

        send(200 << DB, 700);
        wait_wraps(1);
        chk("wrap_cmpH", int'(cmpH), 700);
        chk("wrap_cmpL", int'(cmpL), 100);

        send(800 << DB, 700);
        wait_wraps(1);
        chk("full_cmpL", int'(cmpL), int'(PARK));

        repeat (30) @(posedge clk);
        #1 period = CW'(50);
        wait_wraps(1);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!wrap && cyc < 200);
        chk("period50_interval", cyc, 50);
        @(posedge clk);
        #1;

        send(300 << DB, 10);
        chk("b2b_ready_low", int'(upd_ready), 0);
        send(120 << DB, 40);
        wait_wraps(2);

        period = CW'(20);
        wait_wraps(2);
        send((10 << DB) + 4, 0);
        wait_wraps(1);
        cnt11 = 0;
        for (int k = 0; k < 8; k++) begin
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!wrap && cyc < 100);
            @(negedge clk);
            if (int'(cmpL) - int'(cmpH) == 11) cnt11++;
        end
        chk("dither_11_count", cnt11, 2);
        @(posedge clk);
        #1;

        for (int i = 0; i < 30; i++) begin
            gap = $urandom_range(0, 60);
            repeat (gap) @(posedge clk);
            if (gap > 0) #1;
            if ($urandom_range(0, 3) == 0) period = CW'($urandom_range(0, 40));
            d = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 400);
            send((d << DB) + $urandom_range(0, 15), $urandom_range(0, 639));
        end

        period = CW'(10);
        send(400 << DB, 0);
        wait_wraps(2);
        cyc = 0;
        do begin
            @(negedge clk);
            #1;
            cyc++;
        end while ((expq.size() != 0 || wrap) && cyc < 200);
        chk("sb_drained", expq.size(), 0);
        model_on = 1'b0;
        @(posedge clk);
        #1 en = 1'b0;
        repeat (2) @(negedge clk);
        chk("en0_tb", int'(tb), 0);
        chk("en0_wrap", int'(wrap), 0);
        chk("en0_cmpH", int'(cmpH), int'(PARK));
        chk("en0_cmpL", int'(cmpL), int'(PARK));
        chk("en0_ready", int'(upd_ready), 1);

        @(posedge clk);
        #1 en = 1'b1;
        repeat (14) @(negedge clk);
        chk("reen_cmpH", int'(cmpH), 0);
        chk("reen_cmpL", int'(cmpL), int'(PARK));
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_cmpH", int'(cmpH), int'(PARK));
        chk("async_rst_tb", int'(tb), 0);
        chk("async_rst_wrap", int'(wrap), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
